mem_responder: RTL

MEM_RESPONDER -- requirements
Module: mem_responder

---
 rtl/mem_responder.sv | 125 ++++++++++++
 1 files changed

// File: rtl/mem_responder.sv
// Single-port word memory behind a request/response handshake with a fixed,
// parameterised number of wait cycles between acceptance and completion.
module mem_responder #(
    parameter int unsigned WAIT_CYCLES = 2,
    parameter int unsigned DEPTH       = 512
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        read,
    input  logic        write,
    input  logic [8:0]  address,
    input  logic [31:0] data_in,
    output logic [31:0] data_out,
    output logic        busy,
    output logic        done,
    output logic        err
);

    localparam int unsigned ADDR_W = 9;
    localparam int unsigned DATA_W = 32;
    localparam int unsigned CNT_W  = 4;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WAIT = 2'd1,
        S_RESP = 2'd2
    } state_e;

    state_e              state_q, state_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [DATA_W-1:0]   wdata_q, wdata_d;
    logic                is_wr_q, is_wr_d;
    logic [DATA_W-1:0]   data_out_q, data_out_d;
    logic                busy_q, busy_d;
    logic                done_q, done_d;
    logic                err_q, err_d;
    logic                mem_we;

    logic [DATA_W-1:0]   mem_q [DEPTH];

    // Next-state, request capture and completion actions
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        addr_d     = addr_q;
        wdata_d    = wdata_q;
        is_wr_d    = is_wr_q;
        data_out_d = data_out_q;
        err_d      = 1'b0;
        mem_we     = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (read ^ write) begin
                    state_d = S_WAIT;
                    cnt_d   = CNT_W'(WAIT_CYCLES);
                    addr_d  = address;
                    wdata_d = data_in;
                    is_wr_d = write;
                end else if (read && write) begin
                    err_d = 1'b1;
                end
            end
            S_WAIT: begin
                if (cnt_q != '0) begin
                    cnt_d = cnt_q - CNT_W'(1);
                end else begin
                    state_d = S_RESP;
                    if (is_wr_q) begin
                        mem_we = 1'b1;
                    end else begin
                        data_out_d = mem_q[addr_q];
                    end
                end
            end
            S_RESP: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        busy_d = (state_d != S_IDLE);
        done_d = (state_d == S_RESP);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= S_IDLE;
            cnt_q      <= '0;
            addr_q     <= '0;
            wdata_q    <= '0;
            is_wr_q    <= 1'b0;
            data_out_q <= '0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            addr_q     <= addr_d;
            wdata_q    <= wdata_d;
            is_wr_q    <= is_wr_d;
            data_out_q <= data_out_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            err_q      <= err_d;
        end
    end

    // Storage survives reset; a write aborted by reset never commits
    always_ff @(posedge clk) begin
        if (mem_we && !reset) begin
            mem_q[addr_q] <= wdata_q;
        end
    end

    assign data_out = data_out_q;
    assign busy     = busy_q;
    assign done     = done_q;
    assign err      = err_q;

endmodule
